// File: rtl/lock_pkg.sv
// Shared constants and state type for the lock compare/lockout controller.
//   DIGITS  : enb_cmp strobes that make up one code attempt
//   MAX_ERR : consecutive mismatches that trigger lockout
//   PW_W    : code width in bits
package lock_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned MAX_ERR = 3;
    localparam int unsigned PW_W    = 16;

    // error_counter width is fixed at 3 bits; MAX_ERR must fit in it.
    localparam int unsigned ERR_W = 3;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        StEntry,
        StLockout
    } state_e;

endpackage

// File: rtl/strobe_edge_det.sv
// Rising-edge detector for the digit-entry strobe.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   sig_i  : level input, synchronous to clk_i
//   rise_o : high in the cycle where sig_i is 1 and was 0 on the previous clock
module strobe_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    // A level held high yields a single strobe.
    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/lock_compare_ctrl.sv
// Password-compare and lockout controller for the digital lock.
// Counts enb_cmp strobes; every DIGITS-th strobe compares pw_16bit against password.
// A match unlocks; MAX_ERR consecutive mismatches lock out until rst_out_i.
//   clk_i           : system clock, rising edge
//   rst_ni          : asynchronous active-low reset
//   pw_16bit_i      : user-entered code
//   password_i      : stored reference code
//   enb_cmp_i       : digit-entry strobe (level, rising edge counts)
//   rst_out_i       : lockout-clear / attempt-abort request
//   enb_lock_o      : 1 = code accepted
//   gen_stop_o      : 1 = lockout active
//   error_counter_o : consecutive-mismatch count
//   gen_rst_o       : one-cycle pulse resetting the upstream digit generator
module lock_compare_ctrl
    import lock_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [PW_W-1:0]  pw_16bit_i,
    input  logic [PW_W-1:0]  password_i,
    input  logic             enb_cmp_i,
    input  logic             rst_out_i,
    output logic             enb_lock_o,
    output logic             gen_stop_o,
    output logic [ERR_W-1:0] error_counter_o,
    output logic             gen_rst_o
);

    logic             strobe;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_inc;
    logic             enb_lock_q;
    logic             gen_stop_q;
    logic             gen_rst_q;

    strobe_edge_det u_strobe_edge_det (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (enb_cmp_i),
        .rise_o (strobe)
    );

    assign err_inc = err_q + ERR_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StEntry;
            cnt_q      <= '0;
            err_q      <= '0;
            enb_lock_q <= 1'b0;
            gen_stop_q <= 1'b0;
            gen_rst_q  <= 1'b0;
        end else begin
            gen_rst_q <= 1'b0;
            if (rst_out_i) begin
                // Clear request wins over any strobe in the same cycle.
                state_q    <= StEntry;
                cnt_q      <= '0;
                err_q      <= '0;
                enb_lock_q <= 1'b0;
                gen_stop_q <= 1'b0;
                gen_rst_q  <= 1'b1;
            end else begin
                case (state_q)
                    StEntry: begin
                        if (strobe) begin
                            if (cnt_q == CNT_W'(DIGITS - 1)) begin
                                cnt_q     <= '0;
                                gen_rst_q <= 1'b1;
                                if (pw_16bit_i == password_i) begin
                                    enb_lock_q <= 1'b1;
                                    err_q      <= '0;
                                end else begin
                                    enb_lock_q <= 1'b0;
                                    err_q      <= err_inc;
                                    if (err_inc == ERR_W'(MAX_ERR)) begin
                                        state_q    <= StLockout;
                                        gen_stop_q <= 1'b1;
                                    end
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                                // First digit of a new attempt drops a prior unlock.
                                if (cnt_q == '0) begin
                                    enb_lock_q <= 1'b0;
                                end
                            end
                        end
                    end
                    StLockout: begin
                        gen_stop_q <= 1'b1;
                        enb_lock_q <= 1'b0;
                        err_q      <= ERR_W'(MAX_ERR);
                    end
                    default: begin
                        state_q <= StEntry;
                    end
                endcase
            end
        end
    end

    assign enb_lock_o      = enb_lock_q;
    assign gen_stop_o      = gen_stop_q;
    assign error_counter_o = err_q;
    assign gen_rst_o       = gen_rst_q;

endmodule

// File: tb/tb_lock_compare_ctrl.sv
// Directed plus randomized bench for lock_compare_ctrl with an attempt-level model.
module tb_lock_compare_ctrl;

    localparam int NDIG = 4;
    localparam int NERR = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pw;
    logic [15:0] password;
    logic        enb;
    logic        rst_out;
    logic        enb_lock;
    logic        gen_stop;
    logic [2:0]  error_counter;
    logic        gen_rst;

    int tests = 0;
    int fails = 0;

    // Model state: digits typed so far in this attempt, consecutive errors, lockout flag.
    int m_digits;
    int m_err;
    bit m_locked;
    bit m_lock;
    bit m_grst;
    bit m_prev;

    always #5 clk = ~clk;

    lock_compare_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .pw_16bit_i      (pw),
        .password_i      (password),
        .enb_cmp_i       (enb),
        .rst_out_i       (rst_out),
        .enb_lock_o      (enb_lock),
        .gen_stop_o      (gen_stop),
        .error_counter_o (error_counter),
        .gen_rst_o       (gen_rst)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_digits = 0;
        m_err    = 0;
        m_locked = 0;
        m_lock   = 0;
        m_grst   = 0;
        m_prev   = 0;
    endtask

    // Apply inputs for one cycle, advance the model, then compare all outputs.
    task automatic cycle(input logic e, input logic r);
        bit stb;
        enb     = e;
        rst_out = r;
        stb     = e && !m_prev;
        m_prev  = e;
        m_grst  = 0;
        if (r) begin
            m_locked = 0;
            m_err    = 0;
            m_digits = 0;
            m_lock   = 0;
            m_grst   = 1;
        end else if (!m_locked && stb) begin
            m_digits++;
            if (m_digits == 1) m_lock = 0;
            if (m_digits == NDIG) begin
                m_digits = 0;
                m_grst   = 1;
                if (pw == password) begin
                    m_lock = 1;
                    m_err  = 0;
                end else begin
                    m_lock = 0;
                    m_err++;
                    if (m_err == NERR) m_locked = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("enb_lock", 32'(enb_lock), 32'(m_lock));
        check("gen_stop", 32'(gen_stop), 32'(m_locked));
        check("error_counter", 32'(error_counter), 32'(m_err));
        check("gen_rst", 32'(gen_rst), 32'(m_grst));
    endtask

    task automatic pulse();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    task automatic attempt(input logic [15:0] code);
        pw = code;
        for (int i = 0; i < NDIG; i++) pulse();
    endtask

    initial begin
        rst_n    = 1'b0;
        enb      = 1'b0;
        rst_out  = 1'b0;
        pw       = 16'h0000;
        password = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_enb_lock", 32'(enb_lock), 32'd0);
        check("reset_gen_stop", 32'(gen_stop), 32'd0);
        check("reset_err", 32'(error_counter), 32'd0);
        check("reset_gen_rst", 32'(gen_rst), 32'd0);
        rst_n = 1'b1;

        // Three strobes only: no compare.
        pw = 16'h1234;
        for (int i = 0; i < 3; i++) pulse();
        check("three_strobes_err", 32'(error_counter), 32'd0);
        pulse();
        check("mismatch_err1", 32'(error_counter), 32'd1);

        // Two more mismatches reach lockout.
        attempt(16'h1234);
        attempt(16'h1234);
        check("lockout_stop", 32'(gen_stop), 32'd1);
        check("lockout_err", 32'(error_counter), 32'd3);
        attempt(16'h0000);
        check("lockout_ignored", 32'(enb_lock), 32'd0);

        // Clear and a correct attempt.
        cycle(1'b0, 1'b1);
        check("clear_gen_rst", 32'(gen_rst), 32'd1);
        cycle(1'b0, 1'b0);
        attempt(16'h0000);
        check("match_unlock", 32'(enb_lock), 32'd1);

        // Recovery: two mismatches then a match.
        attempt(16'hbeef);
        attempt(16'hbeef);
        check("recov_err2", 32'(error_counter), 32'd2);
        attempt(16'h0000);
        check("recov_err0", 32'(error_counter), 32'd0);
        check("recov_nostop", 32'(gen_stop), 32'd0);
        cycle(1'b1, 1'b0);
        check("first_strobe_clears", 32'(enb_lock), 32'd0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);

        // Held-high level counts once; rst_out drops a simultaneous strobe.
        pw = 16'h5555;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pulse();
        check("held_and_drop_err", 32'(error_counter), 32'd0);
        pulse();
        check("after_drop_err", 32'(error_counter), 32'd1);

        // Async reset mid-attempt, no clock edge needed.
        pulse();
        pulse();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_err", 32'(error_counter), 32'd0);
        check("async_gen_rst", 32'(gen_rst), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulse();
        pulse();
        check("async_discard", 32'(error_counter), 32'd0);
        pulse();
        pulse();
        check("async_fresh_attempt", 32'(error_counter), 32'd1);

        // Randomized phase against the model.
        password = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            pw = ($urandom_range(0, 1) == 0) ? password : 16'($urandom);
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
